guitar_tone_synth: RTL and testbench

- Downstream of the stage1 record/playback datapath.
- Consumes each 32-bit fret/string note vector (bit 6*k+s = string s pressed at bar k; k=0 means open) and synthesises a polyphonic square-wave tone per string with a decaying envelope.
- Delivers signed 24-bit stereo samples to the DE1 audio-codec FIFO through its allowed/write handshake.

---
 rtl/guitar_tone_synth.sv | 128 ++++++++++++
 tb/tb_guitar_tone_synth.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/guitar_tone_synth.sv
// guitar_tone_synth: six-string square-wave synth with per-string decaying envelopes,
// summed into signed 24-bit stereo samples for the codec FIFO allowed/write handshake.
module guitar_tone_synth #(
    parameter int SAMPLE_DIV   = 1042,
    parameter int DECAY_CYCLES = 195312,
    parameter int AMP_SHIFT    = 12
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        note_valid,
    input  logic [31:0] note,
    input  logic        mute,
    input  logic        audio_out_allowed,
    output logic        write_audio_out,
    output logic [23:0] audio_left,
    output logic [23:0] audio_right,
    output logic [5:0]  active,
    output logic        dropped
);
    typedef enum logic {IDLE, PEND} state_e;
    localparam int SW = $clog2(SAMPLE_DIV + 1);
    localparam int DW = $clog2(DECAY_CYCLES + 1);
    // Half-period ROM in clk cycles: row = string (s0 = high E), column = fret 0..4.
    localparam logic [18:0] HP [6][5] = '{
        '{19'd75843,  19'd71586,  19'd67568,  19'd63776,  19'd60197},
        '{19'd101238, 19'd95556,  19'd90193,  19'd85131,  19'd80353},
        '{19'd127552, 19'd120393, 19'd113636, 19'd107258, 19'd101238},
        '{19'd170262, 19'd160706, 19'd151686, 19'd143173, 19'd135137},
        '{19'd227273, 19'd214517, 19'd202477, 19'd191113, 19'd180387},
        '{19'd303372, 19'd286345, 19'd270272, 19'd255104, 19'd240787}
    };

    logic [SW-1:0]     scnt_q;
    logic [DW-1:0]     dcnt_q;
    logic [7:0]        env_q [6];
    logic [18:0]       cnt_q [6];
    logic [2:0]        fret_q [6];
    logic [5:0]        lvl_q, act_q;
    state_e            state_q;
    logic              wr_q, drop_q;
    logic [23:0]       smp_q;

    logic              s_tick, d_tick;
    logic [5:0]        hit, wrap;
    logic [2:0]        fret_d [6];
    logic signed [11:0] sum_d;
    logic [23:0]       smp_d;
    logic              unused_bits;

    assign unused_bits = ^note[31:30];
    assign s_tick = scnt_q == SW'(SAMPLE_DIV - 1);
    assign d_tick = dcnt_q == DW'(DECAY_CYCLES - 1);

    always_comb begin
        sum_d = '0;
        for (int s = 0; s < 6; s++) begin
            hit[s] = note_valid && (note[s] | note[6+s] | note[12+s] | note[18+s] | note[24+s]);
            fret_d[s] = note[24+s] ? 3'd4 : note[18+s] ? 3'd3 : note[12+s] ? 3'd2 : note[6+s] ? 3'd1 : 3'd0;
            wrap[s] = cnt_q[s] == HP[s][fret_q[s]] - 19'd1;
            if (act_q[s]) sum_d = lvl_q[s] ? sum_d + 12'(env_q[s]) : sum_d - 12'(env_q[s]);
        end
        smp_d = mute ? '0 : {{12{sum_d[11]}}, sum_d} << AMP_SHIFT;
    end

    // A strike overrides oscillator and envelope updates in the same cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int s = 0; s < 6; s++) begin
                env_q[s]  <= '0;
                cnt_q[s]  <= '0;
                fret_q[s] <= '0;
            end
            lvl_q <= '0;
            act_q <= '0;
        end else begin
            for (int s = 0; s < 6; s++) begin
                if (hit[s]) begin
                    env_q[s]  <= 8'd255;
                    cnt_q[s]  <= '0;
                    lvl_q[s]  <= 1'b1;
                    act_q[s]  <= 1'b1;
                    fret_q[s] <= fret_d[s];
                end else if (act_q[s]) begin
                    cnt_q[s] <= wrap[s] ? '0 : cnt_q[s] + 19'd1;
                    lvl_q[s] <= lvl_q[s] ^ wrap[s];
                    if (d_tick) begin
                        env_q[s] <= env_q[s] - 8'd1;
                        if (env_q[s] == 8'd1) begin
                            act_q[s] <= 1'b0;
                            cnt_q[s] <= '0;
                            lvl_q[s] <= 1'b0;
                        end
                    end
                end
            end
        end
    end

    // A sample tick while still pending replaces the unsent sample and takes priority over the write.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            scnt_q  <= '0;
            dcnt_q  <= '0;
            state_q <= IDLE;
            wr_q    <= 1'b0;
            drop_q  <= 1'b0;
            smp_q   <= '0;
        end else begin
            scnt_q <= s_tick ? '0 : scnt_q + SW'(1);
            dcnt_q <= d_tick ? '0 : dcnt_q + DW'(1);
            wr_q   <= 1'b0;
            if (s_tick) begin
                smp_q   <= smp_d;
                state_q <= PEND;
                if (state_q == PEND) drop_q <= 1'b1;
            end else if (state_q == PEND && audio_out_allowed) begin
                wr_q    <= 1'b1;
                state_q <= IDLE;
            end
        end
    end

    assign write_audio_out = wr_q;
    assign audio_left      = smp_q;
    assign audio_right     = smp_q;
    assign active          = act_q;
    assign dropped         = drop_q;
endmodule

// File: tb/tb_guitar_tone_synth.sv
// tb_guitar_tone_synth: random strikes, mute and backpressure checked every cycle against
// a time-based model (strike time, elapsed decay ticks, half-period count), plus literal spot checks.
module tb_guitar_tone_synth;
    localparam int S = 64;
    localparam int D = 250;

    logic        clk = 1'b0, resetn = 1'b0, note_valid = 1'b0, mute = 1'b0, allowed = 1'b1;
    logic [31:0] note = '0;
    logic        wr, drop;
    logic [23:0] al, ar;
    logic [5:0]  act;
    int          pass_n = 0, total_n = 0;

    guitar_tone_synth #(.SAMPLE_DIV(S), .DECAY_CYCLES(D), .AMP_SHIFT(12)) dut (
        .clk(clk), .resetn(resetn), .note_valid(note_valid), .note(note), .mute(mute),
        .audio_out_allowed(allowed), .write_audio_out(wr), .audio_left(al),
        .audio_right(ar), .active(act), .dropped(drop)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total_n++;
        if (got === exp) pass_n++;
        else $display("FAIL %s at %0t: got %h want %h", name, $time, got, exp);
    endtask

    // Model: each string is described by its last strike edge and fret; everything else is derived.
    int          hp [6][5];
    real         open_hp [6] = '{75843.0, 101238.0, 127552.0, 170262.0, 227273.0, 303372.0};
    int          e, se [6], fr [6];
    bit          struck [6];
    bit          pend;
    logic        exp_wr, exp_drop;
    logic [23:0] exp_aud;
    logic [5:0]  exp_act;

    function automatic int ticks(int s, int t);
        return (t + 1) / D - (se[s] + 1) / D;
    endfunction
    function automatic bit alive(int s, int t);
        return struck[s] && ticks(s, t) < 255;
    endfunction
    function automatic int env(int s, int t);
        return 255 - ticks(s, t);
    endfunction
    function automatic bit high(int s, int t);
        return ((t - se[s]) / hp[s][fr[s]]) % 2 == 0;
    endfunction

    initial begin
        int sum, f;
        for (int s = 0; s < 6; s++)
            for (int k = 0; k < 5; k++)
                hp[s][k] = $rtoi(open_hp[s] / $pow(2.0, k / 12.0) + 0.5);
        e = -1;
        forever begin
            @(posedge clk);
            if (!resetn) begin
                e = -1; pend = 0; exp_wr = 0; exp_drop = 0; exp_aud = '0;
                for (int s = 0; s < 6; s++) struck[s] = 0;
            end else begin
                e++;
                if (e % S == S - 1) begin
                    sum = 0;
                    for (int s = 0; s < 6; s++)
                        if (alive(s, e - 1)) sum += high(s, e - 1) ? env(s, e - 1) : -env(s, e - 1);
                    if (pend) exp_drop = 1;
                    exp_aud = mute ? 24'd0 : 24'(sum * 4096);
                    pend = 1;
                    exp_wr = 0;
                end else begin
                    exp_wr = pend && allowed;
                    if (exp_wr) pend = 0;
                end
                if (note_valid)
                    for (int s = 0; s < 6; s++) begin
                        f = -1;
                        for (int k = 0; k < 5; k++) if (note[6*k+s]) f = k;
                        if (f >= 0) begin se[s] = e; fr[s] = f; struck[s] = 1; end
                    end
            end
            exp_act = '0;
            for (int s = 0; s < 6; s++) if (e >= 0 && alive(s, e)) exp_act[s] = 1'b1;
            #1;
            check("write", wr, exp_wr);
            check("left", al, exp_aud);
            check("right", ar, exp_aud);
            check("active", act, exp_act);
            check("dropped", drop, exp_drop);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic strike(input logic [31:0] v);
        note = v; note_valid = 1'b1;
        @(negedge clk);
        note_valid = 1'b0;
    endtask
    task automatic wait_write(input string name, input int limit);
        int n = 0;
        while (wr !== 1'b1 && n < limit) begin @(negedge clk); n++; end
        check(name, wr, 1'b1);
    endtask
    function automatic logic [31:0] rand_note();
        case ($urandom_range(0, 3))
            0: return $urandom();
            1: return 32'd1 << $urandom_range(0, 31);
            2: return $urandom() & $urandom() & $urandom();
            default: return 32'd0;
        endcase
    endfunction

    initial begin
        int wn, es, n;
        cyc(3);
        check("rst_write", wr, 0);
        check("rst_sample", al, 0);
        check("rst_active", act, 0);
        check("rst_dropped", drop, 0);
        resetn = 1'b1;
        wn = 0;
        repeat (3 * S + 1) begin @(negedge clk); wn += int'(wr); end
        check("idle_writes", wn, 3);
        check("idle_active", act, 0);
        strike(32'h0000_003F);
        wait_write("pre_reset_write", S + 4);
        resetn = 1'b0;
        #1;
        check("abort_write", wr, 0);
        check("abort_active", act, 0);
        check("abort_sample", al, 0);
        cyc(2);
        resetn = 1'b1;
        cyc(4);
        strike(32'h0000_0001);
        cyc(2);
        wait_write("first_write", S + 4);
        check("first_sample", al, 24'h0FF000);
        check("first_active", act, 6'b000001);
        allowed = 1'b0;
        wn = 0;
        repeat (2 * S + 2) begin @(negedge clk); wn += int'(wr); end
        check("bp_writes", wn, 0);
        check("bp_dropped", drop, 1);
        allowed = 1'b1;
        wn = 0;
        repeat (30) begin @(negedge clk); wn += int'(wr); end
        check("bp_single_write", wn, 1);
        check("bp_newest", al, 24'h0FF000);
        for (int i = 0; i < 4000; i++) begin
            allowed = $urandom_range(0, 9) != 0;
            if ($urandom_range(0, 199) == 0) mute = ~mute;
            note_valid = $urandom_range(0, 39) == 0;
            if (note_valid) note = rand_note();
            @(negedge clk);
        end
        note_valid = 1'b0; allowed = 1'b1; mute = 1'b1;
        cyc(2);
        strike(32'h0000_003F);
        wn = 0;
        repeat (3 * S) begin
            @(negedge clk);
            wn += int'(wr);
            if (wr) check("mute_sample", al, 0);
        end
        check("mute_writes", wn, 3);
        mute = 1'b0;
        n = 0;
        while (e % D != D - 2 && n < 2 * D) begin @(negedge clk); n++; end
        es = e + 1;
        strike(32'h0100_003F);
        cyc(2);
        wait_write("full_write", S + 4);
        check("full_sample", al, 24'h5FA000);
        check("full_active", act, 6'h3F);
        repeat (es + 255 * D - 1 - e) @(negedge clk);
        check("decay_last_alive", act, 6'h3F);
        @(negedge clk);
        check("decay_fall", act, 0);
        cyc(2);
        wait_write("silent_write", S + 4);
        check("silent_sample", al, 0);
        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end
endmodule
